// File: rtl/sc_collatz_tracker.sv
// Monitors the Collatz datapath output bus: counts steps from a launched seed
// down to 1, tracks the trajectory peak and hands the result over with valid/ack.
module sc_collatz_tracker #(
  parameter int DATAWIDTH_BUS   = 8,
  parameter int DATAWIDTH_STEPS = 8,
  parameter int DATAWIDTH_STALL = 4,
  parameter int STALL_LIMIT     = 15
) (
  input  logic                       SC_COLLATZTRACKER_CLOCK_50,
  input  logic                       SC_COLLATZTRACKER_RESET_InLow,
  input  logic                       SC_COLLATZTRACKER_start_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]   SC_COLLATZTRACKER_data_InBUS,
  input  logic                       SC_COLLATZTRACKER_ack_InHigh,
  output logic [DATAWIDTH_STEPS-1:0] SC_COLLATZTRACKER_steps_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]   SC_COLLATZTRACKER_peak_OutBUS,
  output logic                       SC_COLLATZTRACKER_valid_OutHigh,
  output logic                       SC_COLLATZTRACKER_busy_OutHigh,
  output logic                       SC_COLLATZTRACKER_error_OutHigh
);

  typedef enum logic [1:0] {IDLE, TRACK, REPORT} state_t;

  localparam logic [DATAWIDTH_STEPS-1:0] STEPS_MAX = '1;
  localparam logic [DATAWIDTH_STALL-1:0] STALL_MAX = DATAWIDTH_STALL'(STALL_LIMIT);
  localparam logic [DATAWIDTH_BUS-1:0]   VAL_ZERO  = '0;
  localparam logic [DATAWIDTH_BUS-1:0]   VAL_ONE   = DATAWIDTH_BUS'(1);

  state_t                     state, state_nx;
  logic [DATAWIDTH_STEPS-1:0] steps, steps_nx;
  logic [DATAWIDTH_BUS-1:0]   peak, peak_nx;
  logic [DATAWIDTH_BUS-1:0]   prev, prev_nx;
  logic [DATAWIDTH_STALL-1:0] stall, stall_nx, stall_inc;
  logic                       valid, valid_nx;
  logic                       busy, busy_nx;
  logic                       error, error_nx;

  logic                       clk, rst_n, start, ack;
  logic [DATAWIDTH_BUS-1:0]   data;

  assign clk   = SC_COLLATZTRACKER_CLOCK_50;
  assign rst_n = SC_COLLATZTRACKER_RESET_InLow;
  assign start = SC_COLLATZTRACKER_start_InHigh;
  assign ack   = SC_COLLATZTRACKER_ack_InHigh;
  assign data  = SC_COLLATZTRACKER_data_InBUS;

  assign stall_inc = stall + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      steps <= '0;
      peak  <= '0;
      prev  <= '0;
      stall <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_nx;
      steps <= steps_nx;
      peak  <= peak_nx;
      prev  <= prev_nx;
      stall <= stall_nx;
      valid <= valid_nx;
      busy  <= busy_nx;
      error <= error_nx;
    end
  end

  always_comb begin
    state_nx = state;
    steps_nx = steps;
    peak_nx  = peak;
    prev_nx  = prev;
    stall_nx = stall;
    valid_nx = valid;
    busy_nx  = busy;
    error_nx = error;
    case (state)
      IDLE: begin
        if (start) begin
          steps_nx = '0;
          stall_nx = '0;
          prev_nx  = data;
          if (data == VAL_ZERO) begin
            state_nx = REPORT;
            valid_nx = 1'b1;
            error_nx = 1'b1;
            peak_nx  = '0;
          end else if (data == VAL_ONE) begin
            state_nx = REPORT;
            valid_nx = 1'b1;
            error_nx = 1'b0;
            peak_nx  = VAL_ONE;
          end else begin
            state_nx = TRACK;
            busy_nx  = 1'b1;
            peak_nx  = data;
          end
        end
      end
      TRACK: begin
        if (data != prev) begin
          prev_nx  = data;
          stall_nx = '0;
          if (data > peak) peak_nx = data;
          // A change with a saturated counter cannot be recorded, so the run is aborted.
          if (steps == STEPS_MAX) begin
            state_nx = REPORT;
            valid_nx = 1'b1;
            busy_nx  = 1'b0;
            error_nx = 1'b1;
          end else begin
            steps_nx = steps + 1'b1;
            if (data == VAL_ONE) begin
              state_nx = REPORT;
              valid_nx = 1'b1;
              busy_nx  = 1'b0;
              error_nx = 1'b0;
            end
          end
        end else begin
          stall_nx = stall_inc;
          if (stall_inc == STALL_MAX) begin
            state_nx = REPORT;
            valid_nx = 1'b1;
            busy_nx  = 1'b0;
            error_nx = 1'b1;
          end
        end
      end
      REPORT: begin
        if (ack) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
          error_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign SC_COLLATZTRACKER_steps_OutBUS  = steps;
  assign SC_COLLATZTRACKER_peak_OutBUS   = peak;
  assign SC_COLLATZTRACKER_valid_OutHigh = valid;
  assign SC_COLLATZTRACKER_busy_OutHigh  = busy;
  assign SC_COLLATZTRACKER_error_OutHigh = error;

endmodule

// File: tb/tb_sc_collatz_tracker.sv
// Directed testbench for sc_collatz_tracker: trajectories, trivial seeds,
// stall and step-overflow errors, the handshake and asynchronous reset.
module tb_sc_collatz_tracker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] data;
  logic       ack;
  logic [7:0] steps;
  logic [7:0] peak;
  logic       valid;
  logic       busy;
  logic       error;

  int checks;
  int errors;

  sc_collatz_tracker #(
    .DATAWIDTH_BUS(8),
    .DATAWIDTH_STEPS(8),
    .DATAWIDTH_STALL(4),
    .STALL_LIMIT(15)
  ) dut (
    .SC_COLLATZTRACKER_CLOCK_50(clk),
    .SC_COLLATZTRACKER_RESET_InLow(rst_n),
    .SC_COLLATZTRACKER_start_InHigh(start),
    .SC_COLLATZTRACKER_data_InBUS(data),
    .SC_COLLATZTRACKER_ack_InHigh(ack),
    .SC_COLLATZTRACKER_steps_OutBUS(steps),
    .SC_COLLATZTRACKER_peak_OutBUS(peak),
    .SC_COLLATZTRACKER_valid_OutHigh(valid),
    .SC_COLLATZTRACKER_busy_OutHigh(busy),
    .SC_COLLATZTRACKER_error_OutHigh(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] exp_steps,
                              input logic [7:0] exp_peak, input logic exp_error);
    check({tag, " valid"}, {31'd0, valid}, 32'd1);
    check({tag, " busy"},  {31'd0, busy},  32'd0);
    check({tag, " steps"}, {24'd0, steps}, {24'd0, exp_steps});
    check({tag, " peak"},  {24'd0, peak},  {24'd0, exp_peak});
    check({tag, " error"}, {31'd0, error}, {31'd0, exp_error});
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack valid clear", {31'd0, valid}, 32'd0);
    check("ack error clear", {31'd0, error}, 32'd0);
  endtask

  // Seed 6 trajectory, every value held three cycles.
  task automatic run_seed6(input string tag);
    logic [7:0] seq [7];
    seq = '{8'd3, 8'd10, 8'd5, 8'd16, 8'd8, 8'd4, 8'd2};
    data  = 8'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy after start"}, {31'd0, busy}, 32'd1);
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      data = seq[i];
      for (int k = 0; k < 3; k++) tick();
    end
    check({tag, " not valid before 1"}, {31'd0, valid}, 32'd0);
    check({tag, " busy before 1"}, {31'd0, busy}, 32'd1);
    data = 8'd1;
    tick();
    check_result(tag, 8'd8, 8'd16, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    ack    = 1'b0;
    data   = 8'd0;
    tick();
    check("reset valid", {31'd0, valid}, 32'd0);
    check("reset busy",  {31'd0, busy},  32'd0);
    check("reset error", {31'd0, error}, 32'd0);
    check("reset steps", {24'd0, steps}, 32'd0);
    check("reset peak",  {24'd0, peak},  32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] scenario 1: seed 6");
    run_seed6("seed6");
    do_ack();

    $display("[TB] scenario 2: seeds 1 and 0");
    data  = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_result("seed1", 8'd0, 8'd1, 1'b0);
    do_ack();
    data  = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_result("seed0", 8'd0, 8'd0, 1'b1);
    do_ack();

    $display("[TB] scenario 3: stall");
    data  = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    data = 8'd22;
    tick();
    for (int i = 0; i < 14; i++) tick();
    check("stall not yet", {31'd0, valid}, 32'd0);
    tick();
    check_result("stall", 8'd1, 8'd22, 1'b1);

    $display("[TB] scenario 4: handshake");
    for (int i = 0; i < 20; i++) begin
      start = (i % 5 == 2);
      data  = 8'd6;
      tick();
      check("hold valid", {31'd0, valid}, 32'd1);
      check("hold busy",  {31'd0, busy},  32'd0);
      check("hold steps", {24'd0, steps}, 32'd1);
      check("hold peak",  {24'd0, peak},  32'd22);
      check("hold error", {31'd0, error}, 32'd1);
    end
    start = 1'b1;
    ack   = 1'b1;
    tick();
    start = 1'b0;
    ack   = 1'b0;
    check("start+ack valid", {31'd0, valid}, 32'd0);
    check("start+ack busy",  {31'd0, busy},  32'd0);
    tick();
    tick();
    check("idle stays busy", {31'd0, busy}, 32'd0);
    check("idle stays valid", {31'd0, valid}, 32'd0);
    data  = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    data = 8'd16; tick();
    data = 8'd8;  tick();
    data = 8'd4;  tick();
    data = 8'd2;  tick();
    data = 8'd1;  tick();
    check_result("seed5", 8'd5, 8'd16, 1'b0);
    do_ack();

    $display("[TB] scenario 5: async reset mid-track");
    data  = 8'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    data = 8'd3;  tick();
    data = 8'd10; tick();
    data = 8'd5;  tick();
    check("pre-reset steps", {24'd0, steps}, 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("async valid", {31'd0, valid}, 32'd0);
    check("async busy",  {31'd0, busy},  32'd0);
    check("async error", {31'd0, error}, 32'd0);
    check("async steps", {24'd0, steps}, 32'd0);
    check("async peak",  {24'd0, peak},  32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_seed6("seed6 after reset");
    do_ack();

    $display("[TB] scenario 6: step overflow");
    data  = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 255; i++) begin
      data = (i % 2 == 0) ? 8'd3 : 8'd2;
      tick();
    end
    check("ovf steps at 255", {24'd0, steps}, 32'd255);
    check("ovf still tracking", {31'd0, valid}, 32'd0);
    data = (data == 8'd2) ? 8'd3 : 8'd2;
    tick();
    check_result("ovf", 8'd255, 8'd3, 1'b1);
    do_ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_collatz_tracker.md
Name: sc_collatz_tracker

Overview:
- Downstream monitor of the Collatz system's 8-bit output bus.
- Once a seed is launched, it watches the bus for value changes and counts Collatz steps until the value reaches 1.
- Tracks the peak value of the trajectory.
- Reports steps and peak to a consumer with a valid/ack handshake.
- Flags an error on an invalid seed, a stalled datapath, or step-counter overflow.

Parameters:
- DATAWIDTH_BUS, 8, width of the monitored data bus and of the peak output.
- DATAWIDTH_STEPS, 8, width of the step counter.
- DATAWIDTH_STALL, 4, width of the stall counter.
- STALL_LIMIT, 15, number of consecutive unchanged cycles in TRACK that raises an error. Must exceed the datapath's per-step latency.

Ports:
- SC_COLLATZTRACKER_CLOCK_50  in  1  system clock.
- SC_COLLATZTRACKER_RESET_InLow  in  1  asynchronous reset, active-low.
- SC_COLLATZTRACKER_start_InHigh  in  1  one-cycle pulse; the seed is present on data_InBUS in the same cycle.
- SC_COLLATZTRACKER_data_InBUS  in  DATAWIDTH_BUS  Collatz system output value.
- SC_COLLATZTRACKER_ack_InHigh  in  1  consumer accepts the result.
- SC_COLLATZTRACKER_steps_OutBUS  out  DATAWIDTH_STEPS  number of observed transitions.
- SC_COLLATZTRACKER_peak_OutBUS  out  DATAWIDTH_BUS  maximum value seen, unsigned.
- SC_COLLATZTRACKER_valid_OutHigh  out  1  result available.
- SC_COLLATZTRACKER_busy_OutHigh  out  1  high while in TRACK.
- SC_COLLATZTRACKER_error_OutHigh  out  1  result is invalid; qualified by valid.

Behaviour:
- Reset (async, RESET_InLow=0):
  - state=IDLE.
  - steps, peak, prev, stall counter = 0.
  - valid, busy, error = 0.
  - Reset takes effect immediately in any state, including mid-TRACK and mid-REPORT.
- All outputs are registered.
- States: IDLE, TRACK, REPORT.
- IDLE:
  - start=1, data==0 → REPORT with error=1, steps=0, peak=0.
  - start=1, data==1 → REPORT with error=0, steps=0, peak=1.
  - start=1, any other data → prev=data, peak=data, steps=0, stall=0, busy=1, go TRACK.
  - start=0 → remain in IDLE.
- TRACK, evaluated every cycle:
  - data != prev:
    - steps+1 (if steps already all-ones → REPORT with error=1, steps held at max).
    - prev=data; peak=max(peak,data) unsigned; stall=0.
    - If data==1 → REPORT with error=0.
  - data == prev:
    - stall+1.
    - When the incremented stall equals STALL_LIMIT → REPORT with error=1; steps and peak frozen at their current values.
  - start is ignored in TRACK.
  - Bus wrap-around from datapath overflow is tracked as an ordinary value change; no special handling.
- Latency: the change to 1 is sampled at edge N; valid=1 and busy=0 are visible after edge N, with steps including the final transition.
- REPORT:
  - valid=1; steps, peak and error held stable.
  - ack=1 → IDLE; valid and error clear on the same edge; steps and peak retain their last values.
  - start is ignored in REPORT, including when start and ack are asserted in the same cycle: ack is honoured and a new start is required in IDLE.
- ack is ignored outside REPORT.

Test Plan:
1. Seed 6, bus sequence 6,3,10,5,16,8,4,2,1, each value held 3 cycles → steps=8, peak=16, error=0, valid high 1 cycle after the bus reaches 1; busy low on the same edge.
2. Seed 1 → valid=1 the cycle after start, steps=0, peak=1, error=0, busy never high. Seed 0 → valid=1, error=1, steps=0, peak=0.
3. Seed 7, bus moves to 22 and then freezes → error=1 and valid=1 exactly 15 cycles after the last change, steps=1, peak=22.
4. Handshake:
   - ack held low for 20 cycles after valid → outputs stable throughout.
   - start pulses during REPORT → no effect.
   - start and ack asserted together → return to IDLE, no new run.
   - Next start runs normally.
5. Assert RESET_InLow=0 mid-TRACK (steps=3), asynchronously between clock edges → all outputs 0 immediately. After release, a seed of 6 reproduces scenario 1's result.
6. Force 256 distinct toggles with DATAWIDTH_STEPS=8 → error=1, steps=255 at valid.
